// File: rtl/signed_multi_operand_accumulator_if.sv
// Operand/result stream bundle for signed_multi_operand_accumulator.
// Valid/ready: a beat transfers on a rising edge where valid and ready are both 1; a source holds valid and its data until then.
interface signed_multi_operand_accumulator_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 4
);
    localparam int ACC_W = WIDTH + $clog2(NUM_OPS);

    logic             sat_mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] sum_full;
    logic [WIDTH-1:0] sum;
    logic             overflow;

    modport master (
        output sat_mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, sum_full, sum, overflow
    );

    modport slave (
        input  sat_mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, sum_full, sum, overflow
    );
endinterface

// File: rtl/signed_multi_operand_accumulator.sv
// Streaming signed adder: sums NUM_OPS operands exactly, then presents one
// wrapped or saturated narrow result with an overflow flag.
module signed_multi_operand_accumulator #(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 4
) (
    input  logic clk,
    input  logic rst,
    signed_multi_operand_accumulator_if.slave bus,
    output logic state_dbg
);
    localparam int ACC_W = WIDTH + $clog2(NUM_OPS);
    localparam int CNT_W = $clog2(NUM_OPS);

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] operand_ext;
    logic signed [ACC_W-1:0] acc_nxt;
    logic [ACC_W-WIDTH:0]    top_bits;
    logic                    mode_q;
    logic                    mode_eff;
    logic                    accept;
    logic                    first;
    logic                    last;
    logic                    ovf_nxt;
    logic [WIDTH-1:0]        sum_nxt;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    // in_ready/out_valid depend on state only, so no input-to-output path exists.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (accept && last) state_nxt = OUT;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    assign accept      = bus.in_valid && (state == ACCUM);
    assign first       = (cnt == '0);
    assign last        = (cnt == CNT_W'(NUM_OPS - 1));
    assign operand_ext = {{(ACC_W-WIDTH){bus.in_data[WIDTH-1]}}, bus.in_data};
    assign acc_nxt     = first ? operand_ext : acc + operand_ext;
    assign mode_eff    = first ? bus.sat_mode : mode_q;

    // Narrow result fits only when every bit from the narrow sign bit upward agrees.
    assign top_bits = acc_nxt[ACC_W-1:WIDTH-1];
    assign ovf_nxt  = !((&top_bits) || !(|top_bits));

    always_comb begin
        sum_nxt = acc_nxt[WIDTH-1:0];
        if (mode_eff && ovf_nxt) begin
            if (acc_nxt[ACC_W-1]) sum_nxt = {1'b1, {(WIDTH-1){1'b0}}};
            else                  sum_nxt = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            acc          <= '0;
            mode_q       <= 1'b0;
            bus.sum_full <= '0;
            bus.sum      <= '0;
            bus.overflow <= 1'b0;
        end else if (accept) begin
            acc <= acc_nxt;
            if (first) mode_q <= bus.sat_mode;
            if (last) begin
                cnt          <= '0;
                bus.sum_full <= acc_nxt;
                bus.sum      <= sum_nxt;
                bus.overflow <= ovf_nxt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_signed_multi_operand_accumulator.sv
// Directed bench for signed_multi_operand_accumulator: an 8-bit/4-operand
// instance with hand-computed results and a 12-bit/5-operand instance against an integer model.
module tb_signed_multi_operand_accumulator;
    logic clk;
    logic rst;
    logic a_state;
    logic b_state;
    int   n_total;
    int   n_bad;

    logic [18:0] exp_a_q[$];
    logic [27:0] exp_b_q[$];
    logic [11:0] b_ops [5];

    signed_multi_operand_accumulator_if #(.WIDTH(8),  .NUM_OPS(4)) a_bus ();
    signed_multi_operand_accumulator_if #(.WIDTH(12), .NUM_OPS(5)) b_bus ();

    signed_multi_operand_accumulator #(.WIDTH(8), .NUM_OPS(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (a_bus),
        .state_dbg (a_state)
    );

    signed_multi_operand_accumulator #(.WIDTH(12), .NUM_OPS(5)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (b_bus),
        .state_dbg (b_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state();
        check("a_rst_in_ready",  32'(a_bus.in_ready),  32'd1);
        check("a_rst_out_valid", 32'(a_bus.out_valid), 32'd0);
        check("a_rst_sum_full",  32'(a_bus.sum_full),  32'd0);
        check("a_rst_sum",       32'(a_bus.sum),       32'd0);
        check("a_rst_overflow",  32'(a_bus.overflow),  32'd0);
        check("a_rst_state",     32'(a_state),         32'd0);
        check("b_rst_in_ready",  32'(b_bus.in_ready),  32'd1);
        check("b_rst_sum_full",  32'(b_bus.sum_full),  32'd0);
    endtask

    // driver tasks: inputs change on the falling edge, outputs sampled there too
    task automatic send_a(input logic [7:0] d, input logic m);
        int guard;
        guard = 0;
        @(negedge clk);
        a_bus.in_valid = 1'b1;
        a_bus.in_data  = d;
        a_bus.sat_mode = m;
        while (!a_bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!a_bus.in_ready) check("a_in_ready_timeout", 32'(a_bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        a_bus.in_valid = 1'b0;
    endtask

    task automatic recv_a(input int hold, input bit poke, input bit chk_lat);
        logic [18:0] e;
        int guard;
        guard = 0;
        if (exp_a_q.size() == 0) check("a_sb_empty", 32'(exp_a_q.size()), 32'd1);
        e = exp_a_q.pop_front();
        a_bus.out_ready = 1'b0;
        @(negedge clk);
        while (!a_bus.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("a_out_valid", 32'(a_bus.out_valid), 32'd1);
        if (chk_lat) check("a_latency", 32'(guard), 32'd0);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            if (poke) begin
                a_bus.in_valid = 1'b1;
                a_bus.in_data  = 8'h55;
            end
            check("a_sum_full", 32'(a_bus.sum_full), 32'(e[18:9]));
            check("a_sum",      32'(a_bus.sum),      32'(e[8:1]));
            check("a_overflow", 32'(a_bus.overflow), 32'(e[0]));
            if (hold > 0) begin
                check("a_hold_in_ready",  32'(a_bus.in_ready),  32'd0);
                check("a_hold_out_valid", 32'(a_bus.out_valid), 32'd1);
                check("a_hold_state",     32'(a_state),         32'd1);
            end
        end
        a_bus.out_ready = 1'b1;
        a_bus.in_valid  = 1'b0;
        @(posedge clk);
        #1;
        a_bus.out_ready = 1'b0;
        @(negedge clk);
        check("a_release_out_valid", 32'(a_bus.out_valid), 32'd0);
        check("a_release_in_ready",  32'(a_bus.in_ready),  32'd1);
    endtask

    task automatic group_a(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3,
                           input logic [3:0] modes, input int gap,
                           input logic [9:0] ef, input logic [7:0] es, input logic eo,
                           input int hold, input bit poke);
        exp_a_q.push_back({ef, es, eo});
        send_a(d0, modes[0]);
        repeat (gap) @(negedge clk);
        send_a(d1, modes[1]);
        repeat (gap) @(negedge clk);
        send_a(d2, modes[2]);
        repeat (gap) @(negedge clk);
        send_a(d3, modes[3]);
        recv_a(hold, poke, gap == 0);
    endtask

    function automatic logic [27:0] model_b(input logic mode);
        int s;
        logic ovf;
        logic [11:0] nar;
        s = 0;
        for (int i = 0; i < 5; i++) s += int'($signed(b_ops[i]));
        ovf = (s > 2047) || (s < -2048);
        nar = s[11:0];
        if (ovf && mode) nar = (s > 0) ? 12'h7FF : 12'h800;
        return {s[14:0], nar, ovf};
    endfunction

    task automatic group_b(input logic mode);
        logic [27:0] e;
        int guard;
        exp_b_q.push_back(model_b(mode));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b_bus.in_valid = 1'b1;
            b_bus.in_data  = b_ops[i];
            b_bus.sat_mode = mode;
            guard = 0;
            while (!b_bus.in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!b_bus.in_ready) check("b_in_ready_timeout", 32'(b_bus.in_ready), 32'd1);
            @(posedge clk);
            #1;
            b_bus.in_valid = 1'b0;
        end
        e = exp_b_q.pop_front();
        guard = 0;
        @(negedge clk);
        while (!b_bus.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("b_latency",  32'(guard),          32'd0);
        check("b_sum_full", 32'(b_bus.sum_full), 32'(e[27:13]));
        check("b_sum",      32'(b_bus.sum),      32'(e[12:1]));
        check("b_overflow", 32'(b_bus.overflow), 32'(e[0]));
        b_bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_bus.out_ready = 1'b0;
        @(negedge clk);
        check("b_release_in_ready", 32'(b_bus.in_ready), 32'd1);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        a_bus.in_valid = 1'b0; a_bus.in_data = '0; a_bus.sat_mode = 1'b0; a_bus.out_ready = 1'b0;
        b_bus.in_valid = 1'b0; b_bus.in_data = '0; b_bus.sat_mode = 1'b0; b_bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state();

        // -250: wraps to 0x06, saturates to 0x80
        group_a(8'h92, 8'hBF, 8'hD5, 8'hE0, 4'b0000, 0, 10'h306, 8'h06, 1'b1, 0, 1'b0);
        group_a(8'h92, 8'hBF, 8'hD5, 8'hE0, 4'b0001, 0, 10'h306, 8'h80, 1'b1, 0, 1'b0);
        // +508: saturates to 0x7F, wraps to 0xFC
        group_a(8'h7F, 8'h7F, 8'h7F, 8'h7F, 4'b0001, 0, 10'h1FC, 8'h7F, 1'b1, 0, 1'b0);
        group_a(8'h7F, 8'h7F, 8'h7F, 8'h7F, 4'b0000, 0, 10'h1FC, 8'hFC, 1'b1, 0, 1'b0);
        // no overflow in either mode
        group_a(8'h01, 8'h02, 8'h03, 8'hFC, 4'b0000, 0, 10'h002, 8'h02, 1'b0, 0, 1'b0);
        group_a(8'h01, 8'h02, 8'h03, 8'hFC, 4'b0001, 0, 10'h002, 8'h02, 1'b0, 0, 1'b0);
        // bubbles between operands: 16+32+48+5 = 101
        group_a(8'h10, 8'h20, 8'h30, 8'h05, 4'b0000, 2, 10'h065, 8'h65, 1'b0, 0, 1'b0);
        // output held 3 cycles with 0x55 offered: 64+64-64+1 = 65
        group_a(8'h40, 8'h40, 8'hC0, 8'h01, 4'b0000, 0, 10'h041, 8'h41, 1'b0, 3, 1'b1);
        // 0x55 must not leak into this group: 1+1+1+2 = 5
        group_a(8'h01, 8'h01, 8'h01, 8'h02, 4'b0000, 0, 10'h005, 8'h05, 1'b0, 0, 1'b0);

        // reset mid-group drops the partial sum
        send_a(8'h10, 1'b1);
        send_a(8'h20, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        group_a(8'h01, 8'h01, 8'h01, 8'h01, 4'b0000, 0, 10'h004, 8'h04, 1'b0, 0, 1'b0);

        // mode is taken from the first operand only
        group_a(8'h7F, 8'h7F, 8'h7F, 8'h7F, 4'b1110, 0, 10'h1FC, 8'hFC, 1'b1, 0, 1'b0);
        group_a(8'h7F, 8'h7F, 8'h7F, 8'h7F, 4'b0001, 0, 10'h1FC, 8'h7F, 1'b1, 0, 1'b0);

        // 12-bit, 5-operand instance
        b_ops = '{12'h800, 12'h900, 12'hA00, 12'h7FF, 12'h800};
        group_b(1'b0);
        group_b(1'b1);
        b_ops = '{12'h123, 12'hFFF, 12'h010, 12'h002, 12'hF00};
        group_b(1'b0);
        group_b(1'b1);
        b_ops = '{12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF};
        group_b(1'b1);
        group_b(1'b0);

        // final report
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/signed_multi_operand_accumulator.md
# signed_multi_operand_accumulator

Parametrised, sequential two's-complement multi-operand adder. It accepts NUM_OPS signed operands one per cycle over a valid/ready stream and keeps an exact, growth-safe running sum. After the last operand it presents one result with an overflow flag, in either wrap or saturate mode. It is the streaming successor to the fixed four-operand 8-bit combinational adder and feeds downstream arithmetic through a valid/ready output.

## Interface
- WIDTH, 8: operand and narrow-result width in bits (≥ 2).
- NUM_OPS, 4: operands summed per result (≥ 2).
- ACC_W (localparam), WIDTH + $clog2(NUM_OPS): exact-sum width.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- sat_mode  input  1  0 = wrap, 1 = saturate; sampled only when the first operand of a group is accepted.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  signed operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum_full  output  ACC_W  signed exact sum; never overflows.
- sum  output  WIDTH  signed narrow result, wrapped or saturated per the captured mode.
- overflow  output  1  exact sum lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].

## Operation
- States: ACCUM, OUT.
- ACCUM: in_ready = 1, out_valid = 0. An operand is accepted on in_valid & in_ready.
  - On acceptance, the accumulator updates to acc + sign-extended in_data. For the first operand (cnt == 0) it is loaded with the operand instead, and sat_mode is captured.
  - cnt increments on each acceptance. When cnt == NUM_OPS-1 and an operand is accepted: cnt returns to 0, the next state is OUT, and all outputs are registered from the final sum.
- OUT: out_valid = 1, in_ready = 0; in_valid is ignored. Results hold stable while out_ready = 0. On out_ready = 1, the next state is ACCUM.
- Arithmetic:
  - sum_full is the exact ACC_W-bit sum.
  - overflow = 1 when sum_full[ACC_W-1:WIDTH-1] is not all-equal.
  - Wrap mode: sum = sum_full[WIDTH-1:0].
  - Saturate mode: on overflow, sum = 2^(WIDTH-1)-1 if sum_full is positive, else -2^(WIDTH-1); with no overflow, sum equals the wrapped value.
- A gap in in_valid during ACCUM leaves the partial sum and cnt unchanged. There is no timeout.

## Timing
- Reset (any state, including mid-group): state = ACCUM, cnt = 0, acc = 0, captured mode = 0, out_valid = 0, sum_full = 0, sum = 0, overflow = 0. in_ready = 1 from the first cycle after reset.
- Throughput: one operand per cycle in ACCUM.
- Latency: out_valid rises on the cycle after the clock edge that accepts the NUM_OPS-th operand.
- Minimum group period is NUM_OPS + 1 cycles: NUM_OPS accept cycles plus ≥1 OUT cycle.
- In OUT with out_ready = 1: out_valid drops at the next edge, and in_ready is 1 in that same next cycle.
- rst asserted together with any other event: reset wins.
- in_ready and out_valid are pure functions of state; there is no combinational path from inputs.

## Test plan
- Wrap: WIDTH=8, NUM_OPS=4, sat_mode=0; operands 0x92, 0xBF, 0xD5, 0xE0 back-to-back -> one cycle later out_valid=1, sum_full=10'h306 (-250), sum=8'h06, overflow=1.
- Saturate: same operands with sat_mode=1 at the first operand -> sum=8'h80, overflow=1. Then 0x7F ×4 -> sum_full=10'h1FC (508), sum=8'h7F, overflow=1. With sat_mode=0, the same 0x7F ×4 gives sum=8'hFC.
- No overflow: 0x01, 0x02, 0x03, 0xFC -> sum_full=10'h002, sum=8'h02, overflow=0 in both modes.
- Backpressure and bubbles:
  - Operands delivered with in_valid low between them; sum is correct.
  - out_ready held low for 3 cycles: out_valid and all outputs stay stable, in_ready=0, and in_valid=1 with 0x55 during OUT is not absorbed.
  - out_ready=1: the next cycle in_ready=1.
- Reset mid-group: accept 0x10, 0x20, assert rst for 1 cycle, then send 0x01 ×4 -> sum_full=4, overflow=0, with no contribution from the pre-reset operands.
- Mode capture: sat_mode toggled after the first operand has no effect on the current group. Repeat the wrap and no-overflow scenarios with WIDTH=12, NUM_OPS=5 (ACC_W=15) and check against a reference model.
